// File: rtl/route_pkg.sv
// Shared definitions for the per-port route requester: direction codes,
// packet field offsets and the grant/retry FSM encoding.
package route_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_NONE  = 2'b00;
  localparam dir_t DIR_X     = 2'b01;
  localparam dir_t DIR_Y     = 2'b10;
  localparam dir_t DIR_LOCAL = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } req_state_e;

  // Packet layout is {dst_x, dst_y, payload}; payload sits at bit 0.
  function automatic int unsigned pkt_width(input int unsigned coord_w, input int unsigned pay_w);
    return 2 * coord_w + pay_w;
  endfunction

  function automatic int unsigned dst_y_lsb(input int unsigned pay_w);
    return pay_w;
  endfunction

  function automatic int unsigned dst_x_lsb(input int unsigned coord_w, input int unsigned pay_w);
    return coord_w + pay_w;
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous packet FIFO with occupancy count; pushes are refused while full
// and pops while empty, regardless of the other side.
module pkt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PKT_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [PKT_W-1:0]         din,
  output logic [PKT_W-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/route_request.sv
// Per-input-port requester: queues packets, presents the XY direction of the
// head to the conflict judge and forwards or retries it on the judge's fail bit.
// Optional statistics (retry_max, starve) are built when ROUTE_REQ_STAT_EN is defined.
module route_request
  import route_pkg::*;
#(
  parameter int unsigned COORD_W = 2,
  parameter int unsigned PAY_W   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PKT_W   = 2 * COORD_W + PAY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               control_clk,
  input  logic [COORD_W-1:0] my_x,
  input  logic [COORD_W-1:0] my_y,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PKT_W-1:0]   in_pkt,
  output logic [1:0]         dout,
  input  logic               fail,
`ifdef ROUTE_REQ_STAT_EN
  output logic [7:0]         retry_max,
  output logic               starve,
`endif
  output logic               out_valid,
  output logic [PKT_W-1:0]   out_pkt
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned X_LSB = dst_x_lsb(COORD_W, PAY_W);
  localparam int unsigned Y_LSB = dst_y_lsb(PAY_W);

  req_state_e         state_q;
  req_state_e         state_d;
  logic               push;
  logic               pop;
  logic [PKT_W-1:0]   head;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  dir_t               head_dir;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  pkt_fifo #(
    .DEPTH (DEPTH),
    .PKT_W (PKT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (in_pkt),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign head_x = head[X_LSB +: COORD_W];
  assign head_y = head[Y_LSB +: COORD_W];

  // Dimension-ordered routing: resolve X first, then Y, then deliver locally.
  always_comb begin
    head_dir = DIR_NONE;
    if (empty)                 head_dir = DIR_NONE;
    else if (head_x != my_x)   head_dir = DIR_X;
    else if (head_y != my_y)   head_dir = DIR_Y;
    else                       head_dir = DIR_LOCAL;
  end

  assign dout = (state_q == ST_REQ) ? head_dir : DIR_NONE;

  // Grant/retry FSM; fail is only meaningful in the control_clk==0 phase.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (push) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!control_clk && !fail) begin
          pop = 1'b1;
          if (count == CNT_W'(1) && !push) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      out_valid <= 1'b0;
      out_pkt   <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= pop;
      if (pop) out_pkt <= head;
    end
  end

`ifdef ROUTE_REQ_STAT_EN
  logic [7:0] retry_cnt_q;
  logic [7:0] retry_max_q;
  logic       retry_hit;
  logic [7:0] retry_cnt_inc;

  assign retry_hit     = (state_q == ST_REQ) && !control_clk && fail && (retry_cnt_q != 8'hFF);
  assign retry_cnt_inc = retry_cnt_q + 8'd1;
  assign retry_max     = retry_max_q;
  assign starve        = (retry_cnt_q >= 8'd16);

  // Per-packet retry count saturates; the high-water mark survives pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt_q <= '0;
      retry_max_q <= '0;
    end else begin
      if (pop) begin
        retry_cnt_q <= '0;
      end else if (retry_hit) begin
        retry_cnt_q <= retry_cnt_inc;
        if (retry_cnt_inc > retry_max_q) retry_max_q <= retry_cnt_inc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_route_request.sv
// Self-checking bench for route_request: scoreboard of expected grants plus
// per-scenario inline checks of direction, ready and pulse behaviour.
module tb_route_request;
  import route_pkg::*;

  localparam int unsigned COORD_W = 2;
  localparam int unsigned PAY_W   = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PKT_W   = 2 * COORD_W + PAY_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               control_clk = 1'b1;
  logic [COORD_W-1:0] my_x = 2'd1;
  logic [COORD_W-1:0] my_y = 2'd1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [PKT_W-1:0]   in_pkt = '0;
  logic [1:0]         dout;
  logic               fail = 1'b0;
  logic               out_valid;
  logic [PKT_W-1:0]   out_pkt;
`ifdef ROUTE_REQ_STAT_EN
  logic [7:0]         retry_max;
  logic               starve;
`endif

  logic [PKT_W-1:0] exp_q[$];
  logic [PKT_W-1:0] mon_exp;
  int n_checks = 0;
  int n_pass   = 0;
  int n_grants = 0;

  route_request #(
    .COORD_W (COORD_W),
    .PAY_W   (PAY_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .control_clk (control_clk),
    .my_x        (my_x),
    .my_y        (my_y),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pkt      (in_pkt),
    .dout        (dout),
    .fail        (fail),
`ifdef ROUTE_REQ_STAT_EN
    .retry_max   (retry_max),
    .starve      (starve),
`endif
    .out_valid   (out_valid),
    .out_pkt     (out_pkt)
  );

  always #5 clk = ~clk;

  function automatic logic [PKT_W-1:0] mk(input logic [1:0] x, input logic [1:0] y, input logic [7:0] pay);
    return {x, y, pay};
  endfunction

  // Scoreboard: every grant pulse must match the oldest expected packet.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_grants++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL grant_unexpected: out_pkt=%h but no grant expected", out_pkt);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_pkt !== mon_exp) $display("FAIL grant_pkt: out_pkt=%h expected %h", out_pkt, mon_exp);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; fail = 1'b0; control_clk = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (dout !== DIR_NONE) $display("FAIL reset_dout: got %b expected 00", dout); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_pkt !== '0) $display("FAIL reset_out_pkt: got %h expected 000", out_pkt); else n_pass++;
    rst_n = 1'b1;
    // Idle with fail pulses in the arbitration phase must change nothing.
    control_clk = 1'b0; fail = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (dout !== DIR_NONE) $display("FAIL idle_fail_dout: got %b expected 00", dout); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL idle_fail_in_ready: got %b expected 1", in_ready); else n_pass++;
    fail = 1'b0; control_clk = 1'b1;
  endtask

  task automatic test_single();
    logic [PKT_W-1:0] p;
    p = mk(2'd2, 2'd1, 8'hA5);
    @(negedge clk);
    in_valid = 1'b1; in_pkt = p; exp_q.push_back(p);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (dout !== DIR_X) $display("FAIL single_dout_pre: got %b expected 01", dout); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_ctl_high_no_grant: out_valid=%b expected 0", out_valid); else n_pass++;
    n_checks++; if (dout !== DIR_X) $display("FAIL single_dout_hold: got %b expected 01", dout); else n_pass++;
    control_clk = 1'b0; fail = 1'b0;
    @(negedge clk);
    control_clk = 1'b1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b expected 1", out_valid); else n_pass++;
    n_checks++; if (dout !== DIR_NONE) $display("FAIL single_dout_post: got %b expected 00", dout); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_pulse_width: out_valid=%b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_pkt !== p) $display("FAIL single_out_pkt_hold: got %h expected %h", out_pkt, p); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL single_drain: %0d grants outstanding expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_retry();
    logic [PKT_W-1:0] pa;
    logic [PKT_W-1:0] pb;
    pa = mk(2'd1, 2'd3, 8'h11);
    pb = mk(2'd1, 2'd1, 8'h22);
    @(negedge clk);
    control_clk = 1'b1; in_valid = 1'b1; in_pkt = pa; exp_q.push_back(pa);
    @(negedge clk);
    in_pkt = pb; exp_q.push_back(pb);
    control_clk = 1'b0; fail = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (dout !== DIR_Y) $display("FAIL retry_dout_%0d: got %b expected 10", i, dout); else n_pass++;
      @(negedge clk);
      in_valid = 1'b0;
    end
    n_checks++; if (dout !== DIR_Y) $display("FAIL retry_dout_held: got %b expected 10", dout); else n_pass++;
`ifdef ROUTE_REQ_STAT_EN
    n_checks++; if (retry_max !== 8'd3) $display("FAIL retry_max: got %0d expected 3", retry_max); else n_pass++;
`endif
    fail = 1'b0;
    @(negedge clk);
    control_clk = 1'b1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL retry_grant_a: out_valid=%b expected 1", out_valid); else n_pass++;
    n_checks++; if (dout !== DIR_LOCAL) $display("FAIL retry_dout_local: got %b expected 11", dout); else n_pass++;
    @(negedge clk);
    control_clk = 1'b0;
    @(negedge clk);
    control_clk = 1'b1;
    n_checks++; if (dout !== DIR_NONE) $display("FAIL retry_dout_end: got %b expected 00", dout); else n_pass++;
    @(negedge clk);
    n_checks++; if (exp_q.size() != 0) $display("FAIL retry_drain: %0d grants outstanding expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_full_and_wrap();
    logic [PKT_W-1:0] p5;
    p5 = mk(2'd3, 2'd0, 8'h55);
    @(negedge clk);
    control_clk = 1'b0; fail = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pkt = mk(2'(i), 2'd1, 8'(8'h40 + i));
      exp_q.push_back(in_pkt);
      @(negedge clk);
    end
    n_checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b expected 0", in_ready); else n_pass++;
    in_pkt = p5;
    repeat (20) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL full_no_accept: in_ready=%b expected 0", in_ready); else n_pass++;
    n_checks++; if (dout !== DIR_X) $display("FAIL full_dout: got %b expected 01", dout); else n_pass++;
`ifdef ROUTE_REQ_STAT_EN
    n_checks++; if (starve !== 1'b1) $display("FAIL starve_set: got %b expected 1", starve); else n_pass++;
`endif
    // One grant while in_valid stays high: the full FIFO must not push this cycle.
    fail = 1'b0;
    @(negedge clk);
    fail = 1'b1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL wrap_ready_after_grant: got %b expected 1", in_ready); else n_pass++;
`ifdef ROUTE_REQ_STAT_EN
    n_checks++; if (starve !== 1'b0) $display("FAIL starve_clear: got %b expected 0", starve); else n_pass++;
`endif
    exp_q.push_back(p5);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL wrap_refull: in_ready=%b expected 0", in_ready); else n_pass++;
    fail = 1'b0;
    repeat (5) @(negedge clk);
    control_clk = 1'b1;
    n_checks++; if (exp_q.size() != 0) $display("FAIL wrap_drain: %0d grants outstanding expected 0", exp_q.size()); else n_pass++;
    n_checks++; if (dout !== DIR_NONE) $display("FAIL wrap_dout_end: got %b expected 00", dout); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL wrap_ready_end: got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_reset_mid_retry();
    int grants_before;
    @(negedge clk);
    control_clk = 1'b0; fail = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pkt = mk(2'd0, 2'd0, 8'(8'h70 + i));
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    grants_before = n_grants;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (dout !== DIR_NONE) $display("FAIL midrst_dout: got %b expected 00", dout); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; fail = 1'b0; control_clk = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++; if (n_grants != grants_before) $display("FAIL midrst_no_grant: %0d grants after reset expected 0", n_grants - grants_before); else n_pass++;
    n_checks++; if (dout !== DIR_NONE) $display("FAIL midrst_dout_after: got %b expected 00", dout); else n_pass++;
    control_clk = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_retry();
    test_full_and_wrap();
    test_reset_mid_retry();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/route_request.md
Name: route_request

Overview:
- Per-input-port requester that sits upstream of the conflict judge.
- Buffers incoming packets in a small FIFO and computes the XY-routing direction of the head packet. It presents that direction as dout to the judge.
- Consumes the judge's per-port fail bit: a granted head is forwarded, a failed head is held and retried.
- The router instantiates three of these (X, Y, LOCAL inputs). Their dout outputs drive dout_x, dout_y and dout_local. Each instance's fail input is wired to fail[2], fail[1] and fail[0] respectively.

Parameters:
- COORD_W, 2, width of each destination coordinate field.
- PAY_W, 8, payload width.
- DEPTH, 4, FIFO entries; must be a power of two, minimum 2.
- PKT_W, 2*COORD_W+PAY_W, packet width, derived; layout is {dst_x, dst_y, payload}.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- control_clk  in  1  arbitration phase; fail is valid and acted on only in cycles where control_clk==0.
- my_x  in  COORD_W  this router's X coordinate; static.
- my_y  in  COORD_W  this router's Y coordinate; static.
- in_valid  in  1  upstream packet valid.
- in_ready  out  1  FIFO can accept.
- in_pkt  in  PKT_W  upstream packet.
- dout  out  2  head direction: 00 NONE, 01 X, 10 Y, 11 LOCAL.
- fail  in  1  judge result for this port; 1 = lost arbitration.
- out_valid  out  1  one-cycle pulse, granted packet on out_pkt.
- out_pkt  out  PKT_W  granted packet.

Behaviour:
- Reset (async on rst_n low):
  - FIFO emptied (pointers and count to 0).
  - in_ready=1, dout=00, out_valid=0, out_pkt=0, retry counter=0.
  - A reset in mid-retry drops all held packets; no partial state survives.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = (count != DEPTH), combinational from registered count.
  - No push while full, even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- Direction (combinational from head entry):
  - empty → 00.
  - head dst_x != my_x → 01.
  - else head dst_y != my_y → 10.
  - else → 11.
- Arbitration (state machine, states IDLE, REQ):
  - IDLE: FIFO empty, dout=00. Move to REQ on the cycle after the first push.
  - REQ: dout shows the head direction. On a cycle with control_clk==0:
    - fail==0: pop the head; out_pkt <= head and out_valid <= 1 on the next edge (1-cycle latency). Go to IDLE if count becomes 0, else stay in REQ (the next head is presented the following cycle).
    - fail==1: hold the head, dout unchanged, retry counter increments.
  - On a cycle with control_clk==1, fail is ignored.
  - In IDLE, fail is always ignored.
- Simultaneous push and pop (not full): count is unchanged; head advances.
- The head is never reordered. The retry counter clears on each successful pop.
- out_valid is high for exactly one cycle per granted packet; out_pkt holds its value until the next grant.

Optional Feature:
- ROUTE_REQ_STAT_EN
- When defined:
  - Adds output retry_max (8 bits): the largest retry count seen for any single packet since reset, saturating at 255.
  - Adds output starve (1 bit): asserted while the current head has failed at least 16 consecutive arbitration phases; clears on pop or reset.
- When undefined: neither port exists. The retry counter may be optimised out.

Decomposition:
- Shared package route_pkg holds:
  - direction constants DIR_NONE=2'b00, DIR_X=2'b01, DIR_Y=2'b10, DIR_LOCAL=2'b11;
  - packet field offset helpers;
  - the FSM state encoding.
- Natural sub-module: pkt_fifo (parameterised DEPTH/PKT_W synchronous FIFO with count, async active-low reset). route_request instantiates it and adds direction logic and the grant/retry FSM.

Test Plan:
- Reset then idle, my_x=1, my_y=1 → dout=00, in_ready=1, out_valid=0; fail=1 pulses cause no state change.
- Push one packet with dst (2,1); hold fail=0 on a control_clk==0 cycle → dout=01 before grant; out_valid pulses once on the next cycle with out_pkt equal to the packet; dout returns to 00.
- Push dst (1,3), then dst (1,1); keep fail=1 for 3 arbitration phases, then 0 → dout=10 held through 3 retries (and under STAT_EN, retry_max=3). The first packet is granted, then dout=11 for the second.
- Push 4 packets with fail=1 throughout → in_ready=0 after the 4th; a 5th in_valid is not accepted; count stays at 4.
- Full FIFO, one grant while in_valid is asserted → no push in the grant cycle; push succeeds the next cycle; FIFO order is preserved across pointer wrap.
- Assert rst_n=0 mid-retry with 3 queued → in the same cycle dout=00 and in_ready=1; after release no out_valid appears without new pushes.
